// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Width of the load-use stall counter (LOAD_LAT is 1..7)
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2
  } haz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Why the front of the pipe is being squashed this cycle
  typedef enum logic [1:0] {
    FLUSH_NONE   = 2'd0,
    FLUSH_BRANCH = 2'd1,
    FLUSH_JUMP   = 2'd2,
    FLUSH_IRQ    = 2'd3
  } flush_cause_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. Optional perf counters with HAZ_PERF_EN.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PC_W   = 32
`ifdef HAZ_PERF_EN
  , parameter int unsigned PERF_W = 32
`endif
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs, id_rt;
  logic              id_uses_rs, id_uses_rt;
  logic              id_jump;
  logic [PC_W-1:0]   id_pc;
  logic              ex_memread, ex_regwrite;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              mem_regwrite;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic              mem_busy;
  logic              irq;
  logic              eret;

  logic              pc_write, if_id_write;
  logic              id_ex_hold, ex_mem_hold;
  logic              id_ex_bubble;
  logic              if_id_flush, id_ex_flush;
  logic [1:0]        fwd_a, fwd_b;
  logic              take_irq;
  logic [PC_W-1:0]   epc;
  logic              in_handler;
`ifdef HAZ_PERF_EN
  logic [PERF_W-1:0] stall_cycles, flush_cycles, irq_count;
`endif

  // Pipeline side
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_pc,
           ex_memread, ex_regwrite, ex_rd, ex_branch_taken,
           mem_regwrite, mem_rd, wb_regwrite, wb_rd, mem_busy, irq, eret,
    input  pc_write, if_id_write, id_ex_hold, ex_mem_hold, id_ex_bubble,
           if_id_flush, id_ex_flush, fwd_a, fwd_b, take_irq, epc, in_handler
`ifdef HAZ_PERF_EN
    , input stall_cycles, flush_cycles, irq_count
`endif
  );

  // Hazard controller side
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_pc,
           ex_memread, ex_regwrite, ex_rd, ex_branch_taken,
           mem_regwrite, mem_rd, wb_regwrite, wb_rd, mem_busy, irq, eret,
    output pc_write, if_id_write, id_ex_hold, ex_mem_hold, id_ex_bubble,
           if_id_flush, id_ex_flush, fwd_a, fwd_b, take_irq, epc, in_handler
`ifdef HAZ_PERF_EN
    , output stall_cycles, flush_cycles, irq_count
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Operand forward select for one ID source register; EX/MEM beats MEM/WB.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        sel
);
  // Youngest matching producer wins; $zero never forwards
  always_comb begin
    sel = FWD_RF;
    if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and IRQ-entry controller for the 5-stage pipeline.
// Optional macro HAZ_PERF_EN adds saturating stall/flush/irq perf counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned LOAD_LAT = 1
`ifdef HAZ_PERF_EN
  , parameter int unsigned PERF_W = 32
`endif
) (
  input  logic clk,
  input  logic reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LOAD_LAT - 1);

  haz_state_e       state_q, state_d, eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  epc_q, epc_d;
  logic             in_handler_q, in_handler_d;
  logic             irq_pend_q, irq_pend_d;

  logic             lu_hit, busy_c, br_c, stall_c, jump_c, take_c;
  logic             pc_write_c, if_id_write_c, id_ex_hold_c, ex_mem_hold_c;
  logic             id_ex_bubble_c, if_id_flush_c, id_ex_flush_c;
  flush_cause_e     cause_c;
  logic [1:0]       sel_a, sel_b;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src(hz.id_rs), .mem_we(hz.mem_regwrite), .mem_rd(hz.mem_rd),
    .wb_we(hz.wb_regwrite), .wb_rd(hz.wb_rd), .sel(sel_a)
  );
  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src(hz.id_rt), .mem_we(hz.mem_regwrite), .mem_rd(hz.mem_rd),
    .wb_we(hz.wb_regwrite), .wb_rd(hz.wb_rd), .sel(sel_b)
  );

  // MEMWAIT resumes whatever it interrupted: an unfinished load stall or RUN
  assign eff_state = (state_q == MEMWAIT) ? ((cnt_q != '0) ? LDSTALL : RUN) : state_q;

  assign lu_hit = hz.ex_memread && (hz.ex_rd != '0) &&
                  ((hz.id_uses_rs && (hz.ex_rd == hz.id_rs)) ||
                   (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

  // Priority chain: mem wait > branch > load-use > jump > irq entry
  assign busy_c  = reset && hz.mem_busy;
  assign br_c    = reset && !hz.mem_busy && hz.ex_branch_taken;
  assign stall_c = reset && !hz.mem_busy && !hz.ex_branch_taken &&
                   ((eff_state == LDSTALL) || lu_hit);
  assign jump_c  = reset && !hz.mem_busy && !hz.ex_branch_taken && !stall_c && hz.id_jump;
  assign take_c  = reset && !hz.mem_busy && !hz.ex_branch_taken && !stall_c && !hz.id_jump &&
                   (eff_state == RUN) && irq_pend_q && hz.id_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      epc_q        <= '0;
      in_handler_q <= 1'b0;
      irq_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      epc_q        <= epc_d;
      in_handler_q <= in_handler_d;
      irq_pend_q   <= irq_pend_d;
    end
  end

  // Next state, stall counter and IRQ bookkeeping
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    epc_d        = epc_q;
    in_handler_d = in_handler_q;
    irq_pend_d   = irq_pend_q;
    if (hz.irq && !in_handler_q) irq_pend_d = 1'b1;
    if (hz.eret && in_handler_q) in_handler_d = 1'b0;
    if (busy_c) begin
      state_d = MEMWAIT;
    end else if (br_c) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (stall_c) begin
      if (eff_state == LDSTALL) begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? RUN : LDSTALL;
      end else begin
        cnt_d   = LAT_M1;
        state_d = (LAT_M1 != '0) ? LDSTALL : RUN;
      end
    end else begin
      state_d = RUN;
    end
    if (take_c) begin
      epc_d        = hz.id_pc;
      irq_pend_d   = 1'b0;
      in_handler_d = 1'b1;
    end
  end

  // Pipeline enables, holds and flushes for this cycle
  always_comb begin
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    id_ex_hold_c   = 1'b0;
    ex_mem_hold_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    cause_c        = FLUSH_NONE;
    if (busy_c) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      id_ex_hold_c  = 1'b1;
      ex_mem_hold_c = 1'b1;
    end else if (br_c) begin
      cause_c = FLUSH_BRANCH;
    end else if (stall_c) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_bubble_c = 1'b1;
    end else if (jump_c) begin
      cause_c = FLUSH_JUMP;
    end else if (take_c) begin
      cause_c = FLUSH_IRQ;
    end
    if_id_flush_c = (cause_c != FLUSH_NONE);
    id_ex_flush_c = (cause_c == FLUSH_BRANCH) || (cause_c == FLUSH_IRQ);
  end

  assign hz.pc_write     = pc_write_c;
  assign hz.if_id_write  = if_id_write_c;
  assign hz.id_ex_hold   = id_ex_hold_c;
  assign hz.ex_mem_hold  = ex_mem_hold_c;
  assign hz.id_ex_bubble = id_ex_bubble_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.id_ex_flush  = id_ex_flush_c;
  assign hz.fwd_a        = reset ? sel_a : FWD_RF;
  assign hz.fwd_b        = reset ? sel_b : FWD_RF;
  assign hz.take_irq     = take_c;
  assign hz.epc          = epc_q;
  assign hz.in_handler   = in_handler_q;

`ifdef HAZ_PERF_EN
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] flush_cycles_q, flush_cycles_d;
  logic [PERF_W-1:0] irq_count_q, irq_count_d;

  // Saturating event counters
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    irq_count_d    = irq_count_q;
    if (!pc_write_c && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + PERF_W'(1);
    if ((if_id_flush_c || id_ex_flush_c) && (flush_cycles_q != '1))
      flush_cycles_d = flush_cycles_q + PERF_W'(1);
    if (take_c && (irq_count_q != '1)) irq_count_d = irq_count_q + PERF_W'(1);
  end

  // Perf counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
      irq_count_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
      irq_count_q    <= irq_count_d;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_cycles = flush_cycles_q;
  assign hz.irq_count    = irq_count_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl (LOAD_LAT=3).
module tb_pipe_hazard_ctrl;
  // ctl = {pc_write, if_id_write, id_ex_hold, ex_mem_hold, id_ex_bubble, if_id_flush, id_ex_flush, take_irq}
  localparam logic [7:0] C_RUN    = 8'b1100_0000;
  localparam logic [7:0] C_FREEZE = 8'b0011_0000;
  localparam logic [7:0] C_STALL  = 8'b0000_1000;
  localparam logic [7:0] C_BR     = 8'b1100_0110;
  localparam logic [7:0] C_JMP    = 8'b1100_0100;
  localparam logic [7:0] C_IRQ    = 8'b1100_0111;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5), .PC_W(32)) hz ();

  pipe_hazard_ctrl #(.REG_AW(5), .PC_W(32), .LOAD_LAT(3)) dut (
    .clk(clk), .reset(reset), .hz(hz)
  );

  typedef struct {
    logic rst;
    logic [4:0] rs; logic urs; logic [4:0] rt; logic urt; logic jmp;
    logic exmr; logic [4:0] exrd; logic br;
    logic mwe; logic [4:0] mrd; logic wwe; logic [4:0] wrd; logic busy;
    logic [7:0] ctl; logic [1:0] fa; logic [1:0] fb;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [4:0] rs, input logic urs,
                              input logic [4:0] rt, input logic urt, input logic jmp,
                              input logic exmr, input logic [4:0] exrd, input logic br,
                              input logic mwe, input logic [4:0] mrd, input logic wwe,
                              input logic [4:0] wrd, input logic busy,
                              input logic [7:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.rst = rst; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt; v.jmp = jmp;
    v.exmr = exmr; v.exrd = exrd; v.br = br; v.mwe = mwe; v.mrd = mrd;
    v.wwe = wwe; v.wrd = wrd; v.busy = busy; v.ctl = ctl; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  function automatic vec_t idl(input logic [7:0] ctl);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl, 2'b00, 2'b00);
  endfunction

  function automatic logic [7:0] ctl_now();
    return {hz.pc_write, hz.if_id_write, hz.id_ex_hold, hz.ex_mem_hold,
            hz.id_ex_bubble, hz.if_id_flush, hz.id_ex_flush, hz.take_irq};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    hz.id_rs = v.rs; hz.id_uses_rs = v.urs; hz.id_rt = v.rt; hz.id_uses_rt = v.urt;
    hz.id_jump = v.jmp; hz.ex_memread = v.exmr; hz.ex_regwrite = v.exmr; hz.ex_rd = v.exrd;
    hz.ex_branch_taken = v.br; hz.mem_regwrite = v.mwe; hz.mem_rd = v.mrd;
    hz.wb_regwrite = v.wwe; hz.wb_rd = v.wrd; hz.mem_busy = v.busy;
  endtask

  // Advance to just after the next active edge
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t lu5, lu7, lu3;

  initial begin
    hz.id_valid = 1'b1; hz.irq = 1'b0; hz.eret = 1'b0; hz.id_pc = 32'h0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 2'b00));

    lu5 = mk(1, 0, 0, 5, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0, C_STALL, 2'b00, 2'b00);
    lu7 = mk(1, 7, 1, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, C_STALL, 2'b00, 2'b00);
    lu3 = mk(1, 3, 1, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, C_STALL, 2'b00, 2'b00);

    // reset, then forwarding priority
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 2'b00));
    tbl.push_back(mk(0, 8, 1, 8, 1, 0, 0, 0, 0, 1, 8, 1, 8, 0, C_RUN, 2'b00, 2'b00));
    tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 8, 1, 8, 0, C_RUN, 2'b01, 2'b00));
    tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 9, 1, 8, 0, C_RUN, 2'b10, 2'b00));
    tbl.push_back(mk(1, 0, 1, 9, 1, 0, 0, 0, 0, 1, 9, 1, 8, 0, C_RUN, 2'b00, 2'b01));
    tbl.push_back(mk(1, 9, 1, 8, 1, 0, 0, 0, 0, 1, 9, 1, 8, 0, C_RUN, 2'b01, 2'b10));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, C_RUN, 2'b00, 2'b00));
    // load-use: exactly three stall cycles
    tbl.push_back(lu5);
    tbl.push_back(idl(C_STALL));
    tbl.push_back(idl(C_STALL));
    tbl.push_back(idl(C_RUN));
    // unused source and $zero destination never stall
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 2'b00));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 2'b00));
    // branch cancels a stall
    tbl.push_back(lu7);
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_BR, 2'b00, 2'b00));
    tbl.push_back(idl(C_RUN));
    // mem wait for 4 cycles with one stall cycle left
    tbl.push_back(lu5);
    tbl.push_back(idl(C_STALL));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_FREEZE, 2'b00, 2'b00));
    tbl.push_back(idl(C_STALL));
    tbl.push_back(idl(C_RUN));
    // jump and its priority against the others
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_JMP, 2'b00, 2'b00));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, C_FREEZE, 2'b00, 2'b00));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, C_BR, 2'b00, 2'b00));
    tbl.push_back(lu3);
    tbl.push_back(idl(C_STALL));
    tbl.push_back(idl(C_STALL));
    tbl.push_back(idl(C_RUN));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, C_FREEZE, 2'b00, 2'b00));
    tbl.push_back(idl(C_RUN));

    foreach (tbl[i]) begin
      next();
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d ctl", i), 32'(ctl_now()), 32'(tbl[i].ctl));
      chk($sformatf("vec%0d fwd", i), 32'({hz.fwd_a, hz.fwd_b}), 32'({tbl[i].fa, tbl[i].fb}));
    end

    // IRQ entry, masking and eret
    next(); drive(idl(C_RUN)); hz.id_pc = 32'h0040_0010; hz.irq = 1'b1;
    @(negedge clk); chk("irq_req ctl", 32'(ctl_now()), 32'(C_RUN));
    next(); hz.irq = 1'b0;
    @(negedge clk); chk("irq_take ctl", 32'(ctl_now()), 32'(C_IRQ));
    next(); hz.irq = 1'b1;
    @(negedge clk); chk("irq epc", hz.epc, 32'h0040_0010);
    chk("irq in_handler", 32'(hz.in_handler), 32'd1);
    next(); hz.irq = 1'b0;
    @(negedge clk); chk("masked irq", 32'(ctl_now()), 32'(C_RUN));
    next(); hz.eret = 1'b1;
    @(negedge clk); chk("eret in_handler", 32'(hz.in_handler), 32'd1);
    next(); hz.eret = 1'b0;
    @(negedge clk); chk("after eret in_handler", 32'(hz.in_handler), 32'd0);
    chk("after eret no take", 32'(ctl_now()), 32'(C_RUN));

    // IRQ held off behind a jump
    next(); hz.irq = 1'b1; hz.id_jump = 1'b1; hz.id_pc = 32'h0040_0020;
    @(negedge clk); chk("irq+jump ctl", 32'(ctl_now()), 32'(C_JMP));
    next(); hz.irq = 1'b0;
    @(negedge clk); chk("pend+jump ctl", 32'(ctl_now()), 32'(C_JMP));
    next(); hz.id_jump = 1'b0;
    @(negedge clk); chk("late take ctl", 32'(ctl_now()), 32'(C_IRQ));
    next();
    @(negedge clk); chk("late epc", hz.epc, 32'h0040_0020);

    // eret and irq together: request registers one cycle later
    next(); hz.eret = 1'b1; hz.irq = 1'b1;
    @(negedge clk); chk("eret+irq ctl", 32'(ctl_now()), 32'(C_RUN));
    next(); hz.eret = 1'b0;
    @(negedge clk); chk("irq pend delayed", 32'(ctl_now()), 32'(C_RUN));
    next(); hz.irq = 1'b0;
    @(negedge clk); chk("delayed take", 32'(ctl_now()), 32'(C_IRQ));
    next(); drive(lu5);
    @(negedge clk); chk("handler set", 32'(hz.in_handler), 32'd1);
    chk("stall before reset", 32'(ctl_now()), 32'(C_STALL));

    // reset asserted mid-MEMWAIT
    next(); drive(mk(1, 0, 0, 5, 1, 0, 1, 5, 0, 0, 0, 0, 0, 1, C_FREEZE, 2'b00, 2'b00));
    @(negedge clk); chk("memwait ctl", 32'(ctl_now()), 32'(C_FREEZE));
    next(); drive(mk(0, 0, 0, 5, 1, 0, 1, 5, 0, 1, 5, 0, 0, 1, C_RUN, 2'b00, 2'b00));
    @(negedge clk); chk("in reset ctl", 32'(ctl_now()), 32'(C_RUN));
    chk("in reset fwd", 32'({hz.fwd_a, hz.fwd_b}), 32'd0);
    next(); drive(idl(C_RUN));
    @(negedge clk); chk("post reset ctl", 32'(ctl_now()), 32'(C_RUN));
    chk("post reset epc", hz.epc, 32'd0);
    chk("post reset in_handler", 32'(hz.in_handler), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard, forwarding and interrupt-entry controller for the 5-stage MIPS pipeline. It replaces the single-cycle load-use detector and adds parametrised load latency, EX/MEM and MEM/WB forwarding selects, and branch/jump flushes. It also adds data-memory wait freezing and a precise IRQ entry sequencer that captures the EPC. All pipeline registers (PC, IF/ID, ID/EX, EX/MEM) take their enables and flushes from this block.

Parameters:
REG_AW, 5, register address width
PC_W, 32, PC/EPC width
LOAD_LAT, 1, load-use stall cycles (1..7)
PERF_W, 32, perf counter width (only with HAZ_PERF_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs, id_rt  in  REG_AW  ID source registers
id_uses_rs, id_uses_rt  in  1  ID instruction reads rs/rt
id_jump  in  1  jump decoded in ID (j/jal/jr/jalr)
id_pc  in  PC_W  PC of the ID instruction
ex_memread, ex_regwrite  in  1  EX stage control
ex_rd  in  REG_AW  EX destination
ex_branch_taken  in  1  branch resolved taken in EX
mem_regwrite  in  1  MEM stage control
mem_rd  in  REG_AW  MEM destination
wb_regwrite  in  1  WB stage control
wb_rd  in  REG_AW  WB destination
mem_busy  in  1  data memory/peripheral not ready
irq  in  1  level interrupt request
eret  in  1  handler return, decoded in ID
pc_write, if_id_write  out  1  register enables
id_ex_hold, ex_mem_hold  out  1  freeze the stage
id_ex_bubble  out  1  load zero controls into ID/EX
if_id_flush, id_ex_flush  out  1  squash the stage
fwd_a, fwd_b  out  2  00 regfile, 01 EX/MEM, 10 MEM/WB
take_irq  out  1  one-cycle pulse: PC <- ILLOP
epc  out  PC_W  captured return PC
in_handler  out  1  IRQs masked

Behaviour:
- Reset is synchronous and active-low on reset, sampled on the clk rising edge.
- Reset values: state=RUN, counter=0, epc=0, in_handler=0, irq_pend=0. Enables are 1, all hold/flush/bubble/take outputs 0, fwd=00.
- Forwarding is combinational.
- fwd_a=01 when mem_regwrite, mem_rd!=0 and mem_rd==id_rs.
- Otherwise fwd_a=10 when wb_regwrite, wb_rd!=0 and wb_rd==id_rs.
- Otherwise fwd_a=00. fwd_b uses the same rules on id_rt.
- FSM states: RUN, LDSTALL, MEMWAIT.
- Per-cycle priority, highest first:
  1. mem_busy. All stages frozen: pc_write=if_id_write=0, id_ex_hold=ex_mem_hold=1, no flush. State MEMWAIT; the LDSTALL counter is preserved and resumes afterwards.
  2. ex_branch_taken. if_id_flush=id_ex_flush=1 for 1 cycle. Any load-use stall is cancelled: counter<=0, state<=RUN.
  3. Load-use. Condition: ex_memread, ex_rd!=0, and ex_rd matches a used source. Action: pc_write=if_id_write=0, id_ex_bubble=1.
     - Enter LDSTALL with counter=LOAD_LAT-1; stay while counter!=0, decrementing.
     - Total stall is exactly LOAD_LAT cycles; LOAD_LAT=1 never visits LDSTALL beyond the first cycle.
  4. id_jump. if_id_flush=1 for 1 cycle.
- IRQ handling:
  - irq_pend is set when irq=1 and in_handler=0.
  - The IRQ is taken in the first cycle with state=RUN, no condition 1-4 active, and id_valid=1.
  - That cycle: take_irq=1, epc<=id_pc, if_id_flush=id_ex_flush=1, irq_pend<=0, in_handler<=1.
  - eret while in_handler clears in_handler on the next edge. eret and irq in the same cycle: eret clears first, and irq_pend sets one cycle later.
- Reset asserted mid-stall or mid-IRQ forces the reset values on that edge.

Optional Feature:
HAZ_PERF_EN: adds outputs stall_cycles, flush_cycles and irq_count (PERF_W each).
- stall_cycles counts cycles with pc_write=0; flush_cycles counts cycles with any flush; irq_count counts take_irq pulses.
- All counters saturate at max and clear on reset.
- Without the macro the ports and logic are absent.

Decomposition:
- Package hazard_pkg holds: state encoding (RUN, LDSTALL, MEMWAIT); fwd codes FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10; flush-cause constants.
- Sub-module fwd_select (src, mem_we, mem_rd, wb_we, wb_rd -> sel), instantiated twice for fwd_a and fwd_b.

Test Plan:
- Forwarding: mem_rd=wb_rd=8, both regwrite, id_rs=8 -> fwd_a=01; then mem_rd=9 -> fwd_a=10; then id_rs=0 -> fwd_a=00.
- Load-use: LOAD_LAT=3, ex_memread, ex_rd=5, id_rt=5 used -> pc_write=0 and id_ex_bubble=1 for exactly 3 cycles, then 1.
- Branch during stall: in LDSTALL, ex_branch_taken=1 -> both flushes=1 that cycle; next cycle pc_write=1, state RUN.
- Mem wait: mem_busy high 4 cycles during LDSTALL counter=1 -> all frozen 4 cycles; the remaining stall cycle then completes.
- IRQ: irq pulse while id_pc=0x00400010, no hazards -> next cycle take_irq=1; then epc=0x00400010, in_handler=1; a second irq is ignored until eret.
- Reset mid-MEMWAIT with reset=0 on an edge -> all outputs at reset values on the next cycle.
